// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the register file with integrated scoreboard.
// Port slicing helpers keep the flattened read-port buses indexed the same way everywhere.
package regfile_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = 5;
  localparam int NRD_DEF   = 2;
  localparam int REG_ZERO  = 0;

  function automatic int addr_lsb(input int port, input int aw);
    return port * aw;
  endfunction

  function automatic int data_lsb(input int port, input int xlen);
    return port * xlen;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback side bus of the register file: read ports, writeback, issue and flush.
// The master drives requests (pipeline side), the slave is the register file.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);

  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic                wb_en_i;
  logic [AW-1:0]       wb_addr_i;
  logic [XLEN-1:0]     wb_data_i;
  logic                iss_en_i;
  logic [AW-1:0]       iss_rd_i;
  logic                flush_i;
  logic [AW:0]         busy_cnt_o;

  modport master (
    output rd_addr_i, wb_en_i, wb_addr_i, wb_data_i, iss_en_i, iss_rd_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_cnt_o
  );

  modport slave (
    input  rd_addr_i, wb_en_i, wb_addr_i, wb_data_i, iss_en_i, iss_rd_i, flush_i,
    output rd_data_o, rd_busy_o, busy_cnt_o
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy tracking: flush beats issue, issue beats writeback-clear on the same index.
// Also provides the busy lookup for every read port and a registered popcount of busy bits.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = AW_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    busy,
  output logic [AW:0]       busy_cnt
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      cnt_d;

  function automatic logic valid_idx(input logic [AW-1:0] a);
    return (int'(a) != REG_ZERO) && (int'(a) < NREGS);
  endfunction

  // Clear first, then set, so a new producer supersedes the one completing this cycle.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb_en && valid_idx(wb_addr)) busy_d[wb_addr] = 1'b0;
      if (iss_en && valid_idx(iss_rd)) busy_d[iss_rd] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      busy_cnt <= cnt_d;
    end
  end

  // A completing writeback to the read address satisfies the reader in the same cycle.
  for (genvar k = 0; k < NRD; k++) begin : g_lookup
    logic [AW-1:0] a;
    logic          fwd;
    assign a       = rd_addr[addr_lsb(k, AW) +: AW];
    assign fwd     = (BYPASS != 0) && wb_en && (wb_addr == a);
    assign busy[k] = valid_idx(a) && busy_q[a] && !fwd;
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: N combinational read ports with optional write-through bypass,
// one writeback port, x0 hardwired to zero, and an integrated RAW-hazard scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = AW_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      sb_busy;
  logic                wr_ok;

  function automatic logic valid_idx(input logic [AW-1:0] a);
    return (int'(a) != REG_ZERO) && (int'(a) < NREGS);
  endfunction

  assign wr_ok = bus.wb_en_i && valid_idx(bus.wb_addr_i);

  // Plain flops rather than a memory so every entry can be cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wb_addr_i] <= bus.wb_data_i;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_read
    logic [AW-1:0]   a;
    logic [XLEN-1:0] val;
    assign a = bus.rd_addr_i[addr_lsb(k, AW) +: AW];
    always_comb begin
      val = '0;
      if (rst && valid_idx(a)) begin
        if ((BYPASS != 0) && bus.wb_en_i && (bus.wb_addr_i == a)) val = bus.wb_data_i;
        else                                                       val = regs[a];
      end
    end
    assign rd_data[data_lsb(k, XLEN) +: XLEN] = val;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (bus.iss_en_i),
    .iss_rd   (bus.iss_rd_i),
    .wb_en    (bus.wb_en_i),
    .wb_addr  (bus.wb_addr_i),
    .flush    (bus.flush_i),
    .rd_addr  (bus.rd_addr_i),
    .busy     (sb_busy),
    .busy_cnt (bus.busy_cnt_o)
  );

  assign bus.rd_data_o = rst ? rd_data : '0;
  assign bus.rd_busy_o = rst ? sb_busy : '0;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed hazard/bypass/flush scenarios plus random traffic,
// all checked against an array-based architectural model of registers and busy flags.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();

  regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [XLEN-1:0] model_regs [NREGS];
  bit              model_busy [NREGS];
  int total_checks = 0;
  int bad_checks   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] model_read(input int a);
    if (!rst || a == 0) return '0;
    if (bus.wb_en_i && int'(bus.wb_addr_i) == a) return bus.wb_data_i;
    return model_regs[a];
  endfunction

  function automatic logic model_busy_of(input int a);
    if (!rst || a == 0) return 1'b0;
    if (bus.wb_en_i && int'(bus.wb_addr_i) == a) return 1'b0;
    return model_busy[a];
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(model_busy[i]);
    return n;
  endfunction

  // Drive one cycle of inputs, then compare every read port at the falling edge.
  task automatic applyStimulus(input logic r, input logic wbe, input logic [AW-1:0] wba,
                               input logic [XLEN-1:0] wbd, input logic ise,
                               input logic [AW-1:0] isr, input logic fl,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    rst           = r;
    bus.wb_en_i   = wbe;
    bus.wb_addr_i = wba;
    bus.wb_data_i = wbd;
    bus.iss_en_i  = ise;
    bus.iss_rd_i  = isr;
    bus.flush_i   = fl;
    bus.rd_addr_i = {ra1, ra0};
    @(negedge clk);
    for (int k = 0; k < NRD; k++) begin
      int a;
      a = int'(bus.rd_addr_i[k*AW +: AW]);
      checkOutput($sformatf("rd_data%0d", k), bus.rd_data_o[k*XLEN +: XLEN], model_read(a));
      checkOutput($sformatf("rd_busy%0d", k), 32'(bus.rd_busy_o[k]), 32'(model_busy_of(a)));
    end
  endtask

  // Clock edge: update the model from the applied inputs, then check the registered count.
  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        model_regs[i] = '0;
        model_busy[i] = 1'b0;
      end
    end else begin
      if (bus.wb_en_i && bus.wb_addr_i != 0) model_regs[bus.wb_addr_i] = bus.wb_data_i;
      if (bus.flush_i) begin
        for (int i = 0; i < NREGS; i++) model_busy[i] = 1'b0;
      end else begin
        if (bus.wb_en_i) model_busy[bus.wb_addr_i] = 1'b0;
        if (bus.iss_en_i && bus.iss_rd_i != 0) model_busy[bus.iss_rd_i] = 1'b1;
      end
    end
    #1;
    checkOutput("busy_cnt", 32'(bus.busy_cnt_o), 32'(model_count()));
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      model_regs[i] = '0;
      model_busy[i] = 1'b0;
    end

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 31); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 31); advance();

    // Reset clears a written register
    applyStimulus(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 31); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 31); advance();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5, 31);
    checkOutput("reset_x5", bus.rd_data_o[31:0], 32'h0);
    checkOutput("reset_x31", bus.rd_data_o[63:32], 32'h0);
    checkOutput("reset_cnt", 32'(bus.busy_cnt_o), 32'd0);
    advance();

    // x0 ignores writes and issues
    applyStimulus(1, 0, 0, 0, 1, 10, 0, 0, 0); advance();
    applyStimulus(1, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 10);
    checkOutput("x0_data", bus.rd_data_o[31:0], 32'h0);
    checkOutput("x0_busy", 32'(bus.rd_busy_o[0]), 32'd0);
    advance();
    checkOutput("x0_cnt", 32'(bus.busy_cnt_o), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0); advance();

    // Bypass
    applyStimulus(1, 1, 7, 32'h1234, 0, 0, 0, 0, 7);
    checkOutput("bypass_data1", bus.rd_data_o[63:32], 32'h1234);
    advance();

    // RAW hazard
    applyStimulus(1, 0, 0, 0, 1, 3, 0, 3, 0); advance();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("raw_busy", 32'(bus.rd_busy_o[0]), 32'd1);
    checkOutput("raw_cnt", 32'(bus.busy_cnt_o), 32'd1);
    advance();
    applyStimulus(1, 1, 3, 32'h55, 0, 0, 0, 3, 0);
    checkOutput("raw_wb_busy", 32'(bus.rd_busy_o[0]), 32'd0);
    checkOutput("raw_wb_data", bus.rd_data_o[31:0], 32'h55);
    advance();
    checkOutput("raw_cnt_done", 32'(bus.busy_cnt_o), 32'd0);

    // Set wins over clear
    applyStimulus(1, 0, 0, 0, 1, 9, 0, 9, 0); advance();
    applyStimulus(1, 1, 9, 32'hAB, 1, 9, 0, 9, 0); advance();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 9, 0);
    checkOutput("setwins_busy", 32'(bus.rd_busy_o[0]), 32'd1);
    checkOutput("setwins_data", bus.rd_data_o[31:0], 32'hAB);
    checkOutput("setwins_cnt", 32'(bus.busy_cnt_o), 32'd1);
    advance();

    // Flush drops everything including a same-cycle issue
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0); advance();
    applyStimulus(1, 0, 0, 0, 1, 2, 0, 0, 0); advance();
    applyStimulus(1, 0, 0, 0, 1, 4, 0, 0, 0); advance();
    checkOutput("preflush_cnt", 32'(bus.busy_cnt_o), 32'd4);
    applyStimulus(1, 0, 0, 0, 1, 6, 1, 1, 2); advance();
    checkOutput("flush_cnt", 32'(bus.busy_cnt_o), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 6, 1);
    checkOutput("flush_x6", 32'(bus.rd_busy_o[0]), 32'd0);
    checkOutput("flush_x1", 32'(bus.rd_busy_o[1]), 32'd0);
    advance();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      logic r, wbe, ise, fl;
      r   = ($urandom_range(0, 99) >= 2);
      wbe = ($urandom_range(0, 99) < 50);
      ise = ($urandom_range(0, 99) < 45);
      fl  = ($urandom_range(0, 99) < 4);
      applyStimulus(r, wbe, AW'($urandom_range(0, 31)), $urandom(), ise,
                    AW'($urandom_range(0, 31)), fl,
                    AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      advance();
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
